// File: rtl/lightbike_pkg.sv
// Shared lightbike definitions: orientation and state encodings, default
// step deltas for a 640-pixel-wide screen, and the reversal test.
package lightbike_pkg;

    typedef enum logic [1:0] {
        OR_UP    = 2'b00,
        OR_LEFT  = 2'b01,
        OR_DOWN  = 2'b10,
        OR_RIGHT = 2'b11
    } orient_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam int                 SCREEN_WIDTH_DEFAULT = 640;
    localparam logic signed [31:0] DELTA_UP    = 32'shFFFFFD80;
    localparam logic signed [31:0] DELTA_LEFT  = 32'shFFFFFFFF;
    localparam logic signed [31:0] DELTA_DOWN  = 32'sd640;
    localparam logic signed [31:0] DELTA_RIGHT = 32'sd1;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
        return (req ^ cur) == 2'b10;
    endfunction

endpackage

// File: rtl/orient_delta_lut.sv
// Combinational map from orientation to the signed linear-position step.
module orient_delta_lut
    import lightbike_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEFAULT
) (
    input  logic [1:0]         orient_i,
    output logic signed [31:0] delta_o
);

    localparam logic signed [31:0] ROW = $signed(32'(SCREEN_WIDTH));

    always_comb begin
        delta_o = DELTA_RIGHT;
        case (orient_i)
            OR_UP:    delta_o = -ROW;
            OR_LEFT:  delta_o = DELTA_LEFT;
            OR_DOWN:  delta_o = ROW;
            OR_RIGHT: delta_o = DELTA_RIGHT;
            default:  delta_o = DELTA_RIGHT;
        endcase
    end

endmodule

// File: rtl/orient_to_movement.sv
// Light-bike steering and stepping: buffers one turn request, commits it on
// the game tick, and advances the linear pixel position by one step.
module orient_to_movement
    import lightbike_pkg::*;
#(
    parameter int          SCREEN_WIDTH = 640,
    parameter logic [31:0] START_POS    = 32'd153920,
    parameter logic [1:0]  START_ORIENT = 2'b11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               crash,
    input  logic               tick,
    input  logic               turn_valid,
    input  logic [1:0]         turn_orient,
    output logic [1:0]         orient,
    output logic signed [31:0] move_delta,
    output logic [31:0]        pos,
    output logic               move_valid,
    output logic               turn_reject,
    output logic               halted
);

    state_e      state_q, state_d;
    logic [1:0]  orient_q, orient_d;
    logic [31:0] pos_q, pos_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_q, pend_d;
    logic        move_valid_q, move_valid_d;
    logic        turn_reject_q, turn_reject_d;

    logic        req_vld;
    logic [1:0]  req_orient;
    logic        req_reject;
    logic [1:0]  step_orient;
    logic signed [31:0] step_delta;

    orient_delta_lut #(.SCREEN_WIDTH(SCREEN_WIDTH)) u_cur_delta (
        .orient_i (orient_q),
        .delta_o  (move_delta)
    );

    orient_delta_lut #(.SCREEN_WIDTH(SCREEN_WIDTH)) u_step_delta (
        .orient_i (step_orient),
        .delta_o  (step_delta)
    );

    // Fold this cycle's request into the pending slot so a same-cycle tick sees it.
    always_comb begin
        req_vld    = pend_vld_q;
        req_orient = pend_q;
        req_reject = 1'b0;
        if (turn_valid && state_q != ST_HALT) begin
            if (is_reversal(turn_orient, orient_q)) begin
                req_reject = 1'b1;
            end else if (turn_orient == orient_q) begin
                req_vld = 1'b0;
            end else begin
                req_vld    = 1'b1;
                req_orient = turn_orient;
            end
        end
        step_orient = req_vld ? req_orient : orient_q;
    end

    always_comb begin
        state_d       = state_q;
        orient_d      = orient_q;
        pos_d         = pos_q;
        pend_vld_d    = req_vld;
        pend_d        = req_orient;
        move_valid_d  = 1'b0;
        turn_reject_d = req_reject;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (crash) begin
                    state_d = ST_HALT;
                end else begin
                    if (tick) begin
                        orient_d     = step_orient;
                        pend_vld_d   = 1'b0;
                        pos_d        = pos_q + $unsigned(step_delta);
                        move_valid_d = 1'b1;
                    end
                    if (!enable) state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            orient_q      <= START_ORIENT;
            pos_q         <= START_POS;
            pend_vld_q    <= 1'b0;
            pend_q        <= 2'b00;
            move_valid_q  <= 1'b0;
            turn_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            orient_q      <= orient_d;
            pos_q         <= pos_d;
            pend_vld_q    <= pend_vld_d;
            pend_q        <= pend_d;
            move_valid_q  <= move_valid_d;
            turn_reject_q <= turn_reject_d;
        end
    end

    assign orient      = orient_q;
    assign pos         = pos_q;
    assign move_valid  = move_valid_q;
    assign turn_reject = turn_reject_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: doc/orient_to_movement.md
ORIENT_TO_MOVEMENT -- requirements
Module: orient_to_movement

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640: pixels per row; the vertical move delta magnitude.
REQ-002 Parameter START_POS, default 32'd153920: position loaded at reset.
REQ-003 Parameter START_ORIENT, default 2'b11: orientation loaded at reset.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  level; 1 starts or keeps the bike moving.
REQ-007 crash  input  1  one-cycle pulse; freezes the bike.
REQ-008 tick  input  1  one-cycle game-step pulse.
REQ-009 turn_valid  input  1  turn request strobe.
REQ-010 turn_orient  input  2  requested orientation: 00 up, 01 left, 10 down, 11 right.
REQ-011 orient  output  2  committed orientation.
REQ-012 move_delta  output  32  signed per-step position delta of orient.
REQ-013 pos  output  32  current linear pixel position.
REQ-014 move_valid  output  1  one-cycle pulse after each applied step.
REQ-015 turn_reject  output  1  one-cycle pulse when a request is refused.
REQ-016 halted  output  1  high while in state HALT.

Function
REQ-017 move_delta SHALL be: up -SCREEN_WIDTH (32'hFFFFFD80), left 32'hFFFFFFFF, down +SCREEN_WIDTH, right 32'd1; always a function of the registered orient.
REQ-018 States: IDLE, RUN, HALT. IDLE->RUN when enable=1; RUN->HALT on crash; RUN->IDLE when enable=0; HALT->IDLE only when enable=0; crash has priority over the enable=0 transition.
REQ-019 Turn requests SHALL be accepted only in RUN and IDLE; in HALT, turn_valid SHALL be ignored, with no reject pulse.
REQ-020 A request is a reversal when turn_orient XOR orient == 2'b10; reversals SHALL be dropped, with turn_reject=1 on the next cycle.
REQ-021 A non-reversal request SHALL be stored in a one-deep pending register; a later valid request overwrites it.
REQ-022 A request equal to orient SHALL clear pending.
REQ-023 Reversal checks SHALL always use the committed orient, never the pending value.
REQ-024 On tick in RUN, at that edge: orient <= pending, if present; pending is cleared; pos <= pos + delta(new orient) mod 2^32; move_valid=1 for exactly the next cycle.
REQ-025 turn_valid and tick in the same cycle: the request SHALL be checked against the current orient and, if accepted, applied by that tick (bypass).
REQ-026 tick outside RUN SHALL change nothing, and move_valid SHALL stay 0.
REQ-027 crash and tick in the same cycle: the step SHALL NOT be applied; the state becomes HALT.
REQ-028 Movement SHALL never perform bounds checking; pos wraps modulo 2^32.

Reset
REQ-029 While reset=1, regardless of clock: state IDLE; orient=START_ORIENT; pos=START_POS; pending cleared; move_valid=0; turn_reject=0; halted=0.
REQ-030 Reset asserted mid-step SHALL discard any pending turn and any in-flight move_valid pulse.

Structure
REQ-031 The orientation encodings, the state encoding, and the delta constants for SCREEN_WIDTH=640 SHALL live in a shared lightbike package.
REQ-032 Orientation-to-delta mapping SHALL be one sub-module, orient_delta_lut (2-bit in, 32-bit out), purely combinational.

Verification
REQ-033 Reset with defaults -> orient=11, pos=153920, move_delta=1, all pulses 0.
REQ-034 enable=1, three ticks -> pos=153923; move_valid high the cycle after each tick.
REQ-035 Turn 00 (up) then tick -> orient=00, pos decreases by 640; next tick pos decreases by another 640.
REQ-036 With orient=11, request 01 -> turn_reject pulses and orient is unchanged; the same cycle's tick still moves +1.
REQ-037 Requests 00 then 10 before one tick -> orient=10, delta=+640, no reject (pending overwritten).
REQ-038 crash together with tick -> halted=1, pos unchanged; later ticks ignored; enable=0 -> IDLE, halted=0.
